// File: rtl/adcif_pkg.sv
// Shared definitions for the I2S ADC receiver: sample width, bit counter
// width, receive FSM states and the saturating bit-counter helper.
`timescale 1ns/1ps
package adcif_pkg;

   localparam int SAMPLE_W = 24;
   localparam int CNT_W    = 5;

   // Counter value once a full sample has been packed, and MSB bit position
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0] MSB_POS  = CNT_W'(SAMPLE_W - 1);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      RX_LEFT   = 2'd1,
      RX_RIGHT  = 2'd2
   } adcif_state_t;

   // Bit counter advance: stops at CNT_FULL so that long slots cannot wrap
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] n;
      n = (c < CNT_FULL) ? c + CNT_W'(1) : c;
      return n;
   endfunction

endpackage

// File: rtl/adcif_i2s_rx_sync.sv
// Synchroniser for an externally clocked I2S stream. BCK, LRCK and DATA run
// through identical flop chains; one extra BCK flop gives rising-edge
// detection. The rise pulse and the LRCK/DATA values taken from the same
// stage as the synchronised BCK are registered together, so a consumer sees
// a one-cycle strobe with its matching LRCK and DATA.
`timescale 1ns/1ps
module i2s_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_bck,
   input  logic i_lrck,
   input  logic i_data,
   output logic o_bck_rise,
   output logic o_lrck,
   output logic o_data
);

   logic [SYNC_STAGES-1:0] r_bck_sr;
   logic [SYNC_STAGES-1:0] r_lrck_sr;
   logic [SYNC_STAGES-1:0] r_data_sr;
   logic                   r_bck_d;
   logic                   r_bck_rise;
   logic                   r_lrck;
   logic                   r_data;
   logic                   w_bck_sync;
   logic                   w_lrck_sync;
   logic                   w_data_sync;

   assign w_bck_sync  = r_bck_sr[SYNC_STAGES-1];
   assign w_lrck_sync = r_lrck_sr[SYNC_STAGES-1];
   assign w_data_sync = r_data_sr[SYNC_STAGES-1];

   // Metastability chains: shift each asynchronous input into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bck_sr  <= '0;
         r_lrck_sr <= '0;
         r_data_sr <= '0;
      end else begin
         r_bck_sr  <= {r_bck_sr[SYNC_STAGES-2:0], i_bck};
         r_lrck_sr <= {r_lrck_sr[SYNC_STAGES-2:0], i_lrck};
         r_data_sr <= {r_data_sr[SYNC_STAGES-2:0], i_data};
      end
   end

   // Edge detect on synchronised BCK; register the pulse with aligned LRCK/DATA
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bck_d    <= 1'b0;
         r_bck_rise <= 1'b0;
         r_lrck     <= 1'b0;
         r_data     <= 1'b0;
      end else begin
         r_bck_d    <= w_bck_sync;
         r_bck_rise <= w_bck_sync & ~r_bck_d;
         r_lrck     <= w_lrck_sync;
         r_data     <= w_data_sync;
      end
   end

   assign o_bck_rise = r_bck_rise;
   assign o_lrck     = r_lrck;
   assign o_data     = r_data;

endmodule

// File: rtl/adcif.sv
// I2S receiver for the ADC/line-in path. Deserialises 24-bit left/right
// words from an externally mastered I2S stream and presents each stereo pair
// with a one-cycle sample_valid strobe. Words shorter than 24 bits are
// left-justified and flagged through short_word.
`timescale 1ns/1ps
module adcif
   import adcif_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_i2s_lrck,
   input  logic                i_i2s_bck,
   input  logic                i_i2s_data,
   output logic [SAMPLE_W-1:0] o_left_data,
   output logic [SAMPLE_W-1:0] o_right_data,
   output logic                o_sample_valid,
   output logic                o_short_word
);

   logic                w_rise;
   logic                w_lrck;
   logic                w_bit;
   logic                w_proc;
   logic                w_last;
   logic [CNT_W-1:0]    w_pos;
   logic [SAMPLE_W-1:0] w_word;
   logic                w_short;

   adcif_state_t        r_state;
   adcif_state_t        w_state_nxt;
   logic                w_latch_left;
   logic                w_emit;
   logic                w_clear;

   logic                r_primed;
   logic                r_lrck_prev;
   logic [CNT_W-1:0]    r_cnt;
   logic [SAMPLE_W-1:0] r_word;
   logic [SAMPLE_W-1:0] r_hold_left;
   logic                r_hold_short;
   logic [SAMPLE_W-1:0] r_left_data;
   logic [SAMPLE_W-1:0] r_right_data;
   logic                r_sample_valid;
   logic                r_short_word;

   i2s_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .i_bck      (i_i2s_bck),
      .i_lrck     (i_i2s_lrck),
      .i_data     (i_i2s_data),
      .o_bck_rise (w_rise),
      .o_lrck     (w_lrck),
      .o_data     (w_bit)
   );

   // The first rise after reset only establishes lrck_prev; an LRCK change
   // at a rise marks that rise's bit as the last bit of the previous channel.
   assign w_proc = w_rise & r_primed;
   assign w_last = w_proc & (w_lrck != r_lrck_prev);
   assign w_pos  = MSB_POS - r_cnt;

   // Current word including this rise's bit, MSB first, extra bits dropped
   always_comb begin
      w_word = r_word;
      if (r_cnt < CNT_FULL) begin
         w_word[w_pos] = w_bit;
      end
   end

   // A word is short when fewer than SAMPLE_W bits arrived, counting this one
   assign w_short = (cnt_next(r_cnt) < CNT_FULL);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= WAIT_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and per-rise control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_latch_left = 1'b0;
      w_emit       = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         WAIT_SYNC: begin
            // A falling LRCK starts a left word; its bit is the tail of an
            // unseen right word and is discarded.
            if (w_proc && r_lrck_prev && !w_lrck) begin
               w_state_nxt = RX_LEFT;
               w_clear     = 1'b1;
            end
         end
         RX_LEFT: begin
            if (w_last) begin
               w_state_nxt  = RX_RIGHT;
               w_latch_left = 1'b1;
               w_clear      = 1'b1;
            end
         end
         RX_RIGHT: begin
            if (w_last) begin
               w_state_nxt = RX_LEFT;
               w_emit      = 1'b1;
               w_clear     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = WAIT_SYNC;
         end
      endcase
   end

   // Bit packing, left-word holding register and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_primed       <= 1'b0;
         r_lrck_prev    <= 1'b0;
         r_cnt          <= '0;
         r_word         <= '0;
         r_hold_left    <= '0;
         r_hold_short   <= 1'b0;
         r_left_data    <= '0;
         r_right_data   <= '0;
         r_sample_valid <= 1'b0;
         r_short_word   <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         r_short_word   <= 1'b0;
         if (w_rise) begin
            r_primed    <= 1'b1;
            r_lrck_prev <= w_lrck;
         end
         if (w_proc) begin
            if (w_clear) begin
               r_cnt  <= '0;
               r_word <= '0;
            end else begin
               r_cnt  <= cnt_next(r_cnt);
               r_word <= w_word;
            end
         end
         if (w_latch_left) begin
            r_hold_left  <= w_word;
            r_hold_short <= w_short;
         end
         if (w_emit) begin
            r_left_data    <= r_hold_left;
            r_right_data   <= w_word;
            r_short_word   <= r_hold_short | w_short;
            r_sample_valid <= 1'b1;
         end
      end
   end

   assign o_left_data    = r_left_data;
   assign o_right_data   = r_right_data;
   assign o_sample_valid = r_sample_valid;
   assign o_short_word   = r_short_word;

endmodule

// File: tb/tb_adcif.sv
// Bench for adcif: drives I2S frames (one-BCK-delayed data, LRCK low = left)
// and compares every strobed stereo pair, its short flag and its timing
// against values computed directly from the transmitted words.
`timescale 1ns/1ps
module tb_adcif;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_i2s_lrck;
   logic        i_i2s_bck;
   logic        i_i2s_data;
   logic [23:0] o_left_data;
   logic [23:0] o_right_data;
   logic        o_sample_valid;
   logic        o_short_word;

   always #5 clk = ~clk;

   adcif #(.SYNC_STAGES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_i2s_lrck     (i_i2s_lrck),
      .i_i2s_bck      (i_i2s_bck),
      .i_i2s_data     (i_i2s_data),
      .o_left_data    (o_left_data),
      .o_right_data   (o_right_data),
      .o_sample_valid (o_sample_valid),
      .o_short_word   (o_short_word)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Captured strobes: {short, left, right} and the clk edge count seen
   logic [48:0] act_q[$];
   int          act_cyc_q[$];
   int          short_bad = 0;
   always @(negedge clk) begin
      if (o_sample_valid) begin
         act_q.push_back({o_short_word, o_left_data, o_right_data});
         act_cyc_q.push_back(cyc);
      end else if (o_short_word) begin
         short_bad++;
      end
   end

   logic [48:0] exp_q[$];
   int          fall_q[$];   // edge at which a strobe is due after each 1->0 LRCK rise
   int          n_checks = 0;
   int          n_err = 0;
   int          half = 3;
   logic        prev_ch = 1'b1;
   logic        prev_bit = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: top SAMPLE_W bits of an n-bit MSB-first word, zero padded
   function automatic logic [23:0] model_word(input int n, input logic [63:0] v);
      logic [63:0] t;
      if (n >= 24) t = v >> (n - 24);
      else         t = v << (24 - n);
      return t[23:0];
   endfunction

   // One BCK period: LRCK and delayed data change while BCK is low
   task automatic send_period(input logic ch, input logic b);
      @(negedge clk);
      i_i2s_lrck = ch;
      i_i2s_data = prev_bit;
      i_i2s_bck  = 1'b0;
      repeat (half - 1) @(negedge clk);
      @(negedge clk);
      i_i2s_bck = 1'b1;
      if (prev_ch && !ch) fall_q.push_back(cyc + 4);
      repeat (half - 1) @(negedge clk);
      prev_ch  = ch;
      prev_bit = b;
   endtask

   task automatic send_word(input logic ch, input int n, input logic [63:0] v);
      for (int i = n - 1; i >= 0; i--) send_period(ch, v[i]);
   endtask

   task automatic send_frame(input int n, input logic [63:0] l, input logic [63:0] r,
                             input bit expected);
      send_word(1'b0, n, l);
      send_word(1'b1, n, r);
      if (expected) exp_q.push_back({(n < 24), model_word(n, l), model_word(n, r)});
   endtask

   task automatic lead_in(input int p);
      logic b;
      for (int i = 0; i < p; i++) begin
         b = ($urandom_range(1) != 0);
         send_period(1'b1, b);
      end
   endtask

   task automatic tail();
      send_period(1'b0, 1'b0);
      send_period(1'b0, 1'b0);
      repeat (12) @(negedge clk);
   endtask

   task automatic clear_queues();
      act_q.delete();
      act_cyc_q.delete();
      exp_q.delete();
      fall_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_i2s_bck = 1'b0; i_i2s_lrck = 1'b0; i_i2s_data = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_queues();
      prev_ch = 1'b1;
      prev_bit = 1'b0;
   endtask

   task automatic cmp_segment(input string tag);
      check($sformatf("%s.count", tag), act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d].left", tag, i),  act_q[i][47:24], exp_q[i][47:24]);
         check($sformatf("%s[%0d].right", tag, i), act_q[i][23:0],  exp_q[i][23:0]);
         check($sformatf("%s[%0d].short", tag, i), act_q[i][48],    exp_q[i][48]);
         if (i + 1 < fall_q.size())
            check($sformatf("%s[%0d].latency", tag, i), act_cyc_q[i], fall_q[i + 1]);
      end
   endtask

   initial begin
      logic [63:0] l, r;
      logic        b;
      rst = 1'b1;
      i_i2s_bck = 1'b0; i_i2s_lrck = 1'b0; i_i2s_data = 1'b0;

      // Reset state
      do_reset();
      check("reset.left",  o_left_data, 0);
      check("reset.right", o_right_data, 0);
      check("reset.valid", o_sample_valid, 0);
      check("reset.short", o_short_word, 0);

      // Idle: 64 BCK periods with LRCK held low
      for (int i = 0; i < 64; i++) begin
         b = ($urandom_range(1) != 0);
         send_period(1'b0, b);
      end
      repeat (12) @(negedge clk);
      check("idle.count", act_q.size(), 0);
      check("idle.left",  o_left_data, 0);
      check("idle.right", o_right_data, 0);
      check("idle.short", o_short_word, 0);

      // 32-bit slots, fixed values, stream entered mid-right
      do_reset();
      lead_in(5);
      for (int f = 0; f < 4; f++) send_frame(32, 64'h1234_5600, 64'hABCD_EF00, 1);
      tail();
      cmp_segment("w32");

      // 24-bit slots, extreme values
      do_reset();
      lead_in(3);
      for (int f = 0; f < 2; f++) send_frame(24, 64'h80_0000, 64'h7F_FFFF, 1);
      tail();
      cmp_segment("w24");
      if (act_q.size() > 0) begin
         check("w24.left_exact",  act_q[0][47:24], 24'h800000);
         check("w24.right_exact", act_q[0][23:0],  24'h7FFFFF);
      end

      // 16-bit slots: left-justified and flagged short
      do_reset();
      lead_in(3);
      for (int f = 0; f < 2; f++) send_frame(16, 64'h8001, 64'h7FFE, 1);
      tail();
      cmp_segment("w16");
      check("w16.left_exact",  o_left_data, 24'h800100);
      check("w16.right_exact", o_right_data, 24'h7FFE00);

      // Reset in the middle of a left word
      do_reset();
      lead_in(3);
      l = 64'($urandom()) & 64'hFF_FFFF;
      r = 64'($urandom()) & 64'hFF_FFFF;
      send_frame(24, l, r, 1);
      l = 64'($urandom()) & 64'hFF_FFFF;
      for (int i = 23; i >= 12; i--) send_period(1'b0, l[i]);
      cmp_segment("rstA");
      @(negedge clk);
      i_i2s_bck = 1'b0;
      rst = 1'b1;
      #1;
      check("rst.left",  o_left_data, 0);
      check("rst.right", o_right_data, 0);
      check("rst.valid", o_sample_valid, 0);
      check("rst.short", o_short_word, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_queues();
      for (int i = 11; i >= 0; i--) send_period(1'b0, l[i]);
      r = 64'($urandom()) & 64'hFF_FFFF;
      send_word(1'b1, 24, r);
      l = 64'($urandom()) & 64'hFF_FFFF;
      r = 64'($urandom()) & 64'hFF_FFFF;
      send_frame(24, l, r, 1);
      tail();
      cmp_segment("rstB");

      // f_clk = 4 * f_bck, 32-bit slots, random samples
      half = 2;
      do_reset();
      lead_in(4);
      for (int f = 0; f < 100; f++) begin
         l = 64'($urandom());
         r = 64'($urandom());
         send_frame(32, l, r, 1);
      end
      tail();
      cmp_segment("rand");

      check("short_only_with_valid", short_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/adcif.md
# adcif

I2S receiver for the ADC/line-in path; the counterpart of the DAC-side I2S transmitter. It accepts an externally mastered I2S stream (LRCK, BCK, DATA asynchronous to `clk`) and synchronises it into the `clk` domain. It deserialises the left and right 24-bit two's-complement words and presents each stereo pair with a one-cycle `sample_valid` strobe to the downstream sample consumer.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per I2S input (≥2).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i2s_lrck`  in  1  word select; low = left, high = right.
- `i2s_bck`  in  1  bit clock; data sampled on its rising edge.
- `i2s_data`  in  1  serial data, MSB first, standard I2S one-BCK delay.
- `left_data`  out  24  left sample, two's complement.
- `right_data`  out  24  right sample, two's complement.
- `sample_valid`  out  1  one-`clk` pulse when a new stereo pair is on `left_data`/`right_data`.
- `short_word`  out  1  qualifies `sample_valid`: either word of the pair had fewer than 24 bits.

## Operation
- All three I2S inputs pass through identical `SYNC_STAGES` synchronisers, plus one extra BCK stage for edge detection. A BCK rise is `bck_sync & !bck_d`; DATA and LRCK are taken from the same stage as `bck_sync`.
- Per detected BCK rise:
  - sample `lrck_now` and `bit`;
  - the bit belongs to the channel given by `lrck_prev`, which is the LRCK value at the previous rise;
  - if `lrck_now != lrck_prev`, that bit is the final bit of the word;
  - then `lrck_prev <= lrck_now`.
- Packing: a 5-bit counter `cnt` is cleared at word end. Each bit with `cnt < 24` is written to position `23-cnt`, and `cnt` increments, saturating at 24. Bits beyond 24 are ignored. Unfilled LSBs read as 0 (left-justified), and a word ending with `cnt < 24` is short.
- `primed` flag: cleared by reset and set on the first BCK rise after reset. That first rise only loads `lrck_prev`, and its bit is discarded.
- FSM states: `WAIT_SYNC`, `RX_LEFT`, `RX_RIGHT`.
  - `WAIT_SYNC`: on a primed rise with a falling LRCK (1→0), go to `RX_LEFT`, with the counter cleared and the bit discarded.
  - `RX_LEFT`: at word end (LRCK 0→1), latch the left word and its short flag into a holding register, then go to `RX_RIGHT`.
  - `RX_RIGHT`: at word end (LRCK 1→0):
    - drive `left_data` from the hold register and `right_data` from the right word;
    - set `short_word` to the OR of both short flags;
    - pulse `sample_valid`;
    - go to `RX_LEFT`.
- Outputs hold their value between pulses. `short_word` is valid only with `sample_valid`, and is 0 otherwise.
- A word with zero bits (LRCK toggling on consecutive rises) yields a 0 word and sets short.

## Timing
- Reset values: `left_data = 0`, `right_data = 0`, `sample_valid = 0`, `short_word = 0`. Also: FSM `WAIT_SYNC`, synchronisers 0, `primed = 0`, `cnt = 0`.
- Latency: with `SYNC_STAGES = 2`, an input BCK rise first sampled at `clk` edge k is processed at edge k+3. `sample_valid` is high for the single cycle after edge k+3 of the BCK rise carrying the right LSB.
- Input constraints:
  - BCK high and low phases each ≥ 2 `clk` periods, i.e. f_clk ≥ 4·f_bck;
  - DATA and LRCK stable ≥ 1 `clk` period either side of each BCK rise.
- Behaviour outside these constraints is undefined, but must never lock the FSM.
- `rst` mid-word: immediate return to the reset state. The partial frame is lost, and the first `sample_valid` follows the first complete left+right pair after a resynchronising 1→0 LRCK edge.
- At most one `sample_valid` per LRCK period.

## Structure
- Shared package `adcif_pkg`: `SAMPLE_W = 24`, `CNT_W = 5`, FSM state enum.
- One sub-module, `i2s_rx_sync`: parameterised synchroniser for BCK/LRCK/DATA with a registered BCK-rise pulse output. It is reusable by other I2S sinks.

## Test plan
- Reset, then 64 idle BCK periods with LRCK constant: all outputs stay 0 and no `sample_valid`.
- 32 BCK/channel frames, left `0x123456`, right `0xABCDEF`, stream started mid-right:
  - the first partial frame is discarded;
  - then exactly one `sample_valid` per frame with those values and `short_word = 0`.
- 24 BCK/channel, left `0x800000`, right `0x7FFFFF`: exact values, `short_word = 0`.
- 16 BCK/channel, left `0x8001`, right `0x7FFE`: `left_data = 0x800100`, `right_data = 0x7FFE00`, `short_word = 1`.
- `rst` pulsed mid-left word:
  - outputs go to 0 within the reset cycle;
  - the next `sample_valid` occurs only after the first complete post-reset left+right frame, carrying that frame's values.
- f_clk = 4·f_bck with 32-bit words and random samples over 100 frames: all pairs match the bench model, with no missed or duplicate strobes.
